// File: rtl/core_pkg.sv
// Shared core types: data width, reset vector and the
// address/instruction pair carried from prefetch to fetch.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] inst;
    } inst_entry_t;

    // Sequential word address, wrapping at the top of the space
    function automatic logic [XLEN-1:0] next_word(
        input logic [XLEN-1:0] a
    );
        return a + XLEN'(4);
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// In-order FIFO of fetched instructions with synchronous clear.
// Registered head, no bypass from push to head.
module inst_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  inst_entry_t              push_data,
    input  logic                     pop,
    input  logic                     clear,
    output inst_entry_t              head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    inst_entry_t      mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage and pointers; clear drops everything at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher: issues word fetches, buffers
// responses, and discards in-flight words after a redirect.
module inst_prefetch
    import core_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_addr_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    input  logic            inst_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic            boot_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] rsp_addr_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     inflight;
    logic [XLEN-1:0] target;
    logic            gnt_fire;
    logic            rsp;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    inst_entry_t     push_data;
    inst_entry_t     head;
    logic            unused_flush_lsb;

    assign unused_flush_lsb = ^flush_addr_i[1:0];
    assign target = {flush_addr_i[XLEN-1:2], 2'b00};

    // Every issued fetch must have a FIFO slot reserved for it
    assign inflight  = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign mem_req_o = boot_q & ~flush_i & (inflight < DEPTH_W);
    assign mem_addr_o = fetch_pc_q;

    assign gnt_fire = mem_req_o & mem_gnt_i;
    assign rsp      = mem_rvalid_i & (outstanding_q != '0);
    assign rsp_drop = rsp & (drop_q != '0);
    assign push     = rsp & ~rsp_drop & ~flush_i;
    assign pop      = ~fifo_empty & inst_ready_i & ~flush_i;

    assign outstanding_next = outstanding_q
                            + CW'(gnt_fire)
                            - CW'(rsp);

    assign push_data = '{addr: rsp_addr_q, inst: mem_rdata_i};

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (flush_i),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign inst_valid_o = ~fifo_empty;
    assign inst_o       = head.inst;
    assign inst_addr_o  = head.addr;

    // Fetch/response addresses and in-flight bookkeeping;
    // after a redirect every word still in flight is stale
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            boot_q        <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            rsp_addr_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            boot_q        <= 1'b1;
            outstanding_q <= outstanding_next;
            if (flush_i) begin
                fetch_pc_q <= target;
                rsp_addr_q <= target;
                drop_q     <= outstanding_next;
            end else begin
                if (gnt_fire) begin
                    fetch_pc_q <= next_word(fetch_pc_q);
                end
                if (push) begin
                    rsp_addr_q <= next_word(rsp_addr_q);
                end
                if (rsp_drop) begin
                    drop_q <= drop_q - CW'(1);
                end
            end
        end
    end

    a_no_orphan_rsp: assert property (
        @(posedge clk) disable iff (!rst)
        !(mem_rvalid_i && outstanding_q == '0)
    );

    a_no_push_full: assert property (
        @(posedge clk) disable iff (!rst)
        !(push && fifo_full)
    );

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch with an in-order memory model
// of programmable latency; rdata is the word address xor a key.
module tb_inst_prefetch;

    localparam logic [31:0] KEY = 32'h1234_5678;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;
    int cyc      = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];

    inst_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .flush_addr_i (flush_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_ready_i (inst_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory response side: drives rvalid just after each edge
    initial begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (!rst) begin
                pend.delete();
            end else if (pend.size() > 0) begin
                if (pend[0].due <= cyc) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = pend[0].addr ^ KEY;
                    void'(pend.pop_front());
                end
            end
        end
    end

    // Memory request side: records grants late in the cycle
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst && mem_req_o && mem_gnt_i) begin
                pend.push_back('{addr: mem_addr_o, due: cyc + lat});
            end
        end
    end

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Leaves the bench just after the edge that starts cycle 0
    task automatic do_reset(input int l);
        rst     = 1'b0;
        flush_i = 1'b0;
        lat     = l;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] a);
        check({tag, "_vld"}, {31'b0, inst_valid_o}, 32'd1);
        check({tag, "_addr"}, inst_addr_o, a);
        check({tag, "_inst"}, inst_o, a ^ KEY);
    endtask

    initial begin
        rst          = 1'b0;
        flush_i      = 1'b0;
        flush_addr_i = '0;
        mem_gnt_i    = 1'b1;
        inst_ready_i = 1'b1;

        // Reset state
        #2;
        check("rst_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_vld", {31'b0, inst_valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_iaddr", inst_addr_o, 32'd0);

        // Streaming with 1-cycle memory and ready consumer
        do_reset(1);
        inst_ready_i = 1'b1;
        mid();
        check("s_req_c0", {31'b0, mem_req_o}, 32'd0);
        for (int c = 1; c <= 10; c++) begin
            nxt();
            mid();
            check("s_req", {31'b0, mem_req_o}, 32'd1);
            check("s_addr", mem_addr_o, 32'(4 * (c - 1)));
            if (c < 3) begin
                check("s_vld_early", {31'b0, inst_valid_o}, 32'd0);
            end else begin
                chk_head("s_head", 32'(4 * (c - 3)));
            end
        end

        // Redirect near the top of memory: wrap-around
        nxt();
        flush_i      = 1'b1;
        flush_addr_i = 32'hFFFF_FFFA;
        mid();
        check("w_req_f", {31'b0, mem_req_o}, 32'd0);
        nxt();
        flush_i = 1'b0;
        mid();
        check("w_addr0", mem_addr_o, 32'hFFFF_FFF8);
        check("w_vld0", {31'b0, inst_valid_o}, 32'd0);
        nxt();
        mid();
        check("w_addr1", mem_addr_o, 32'hFFFF_FFFC);
        check("w_vld1", {31'b0, inst_valid_o}, 32'd0);
        nxt();
        mid();
        check("w_addr2", mem_addr_o, 32'h0000_0000);
        chk_head("w_h0", 32'hFFFF_FFF8);
        nxt();
        mid();
        chk_head("w_h1", 32'hFFFF_FFFC);
        nxt();
        mid();
        chk_head("w_h2", 32'h0000_0000);

        // Consumer stalled: exactly DEPTH fetches, head held
        do_reset(1);
        inst_ready_i = 1'b0;
        mid();
        for (int c = 1; c <= 12; c++) begin
            nxt();
            mid();
            check("b_req", {31'b0, mem_req_o}, (c <= 4) ? 32'd1 : 32'd0);
            if (c >= 3) chk_head("b_hold", 32'h0);
        end
        for (int c = 13; c <= 20; c++) begin
            nxt();
            inst_ready_i = 1'b1;
            mid();
            chk_head("b_run", 32'(4 * (c - 13)));
            if (c == 14) check("b_addr14", mem_addr_o, 32'h10);
        end

        // Redirect with two fetches outstanding, 3-cycle memory
        do_reset(3);
        inst_ready_i = 1'b1;
        mid();
        nxt();
        mid();
        nxt();
        mid();
        nxt();
        flush_i      = 1'b1;
        flush_addr_i = 32'h0000_0103;
        mid();
        check("f_req_f", {31'b0, mem_req_o}, 32'd0);
        nxt();
        flush_i = 1'b0;
        mid();
        check("f_req4", {31'b0, mem_req_o}, 32'd1);
        check("f_addr4", mem_addr_o, 32'h100);
        for (int c = 4; c <= 7; c++) begin
            if (c > 4) begin
                nxt();
                mid();
            end
            check("f_vld_lo", {31'b0, inst_valid_o}, 32'd0);
        end
        nxt();
        mid();
        chk_head("f_h0", 32'h100);
        nxt();
        mid();
        chk_head("f_h1", 32'h104);

        // Redirect in the same cycle as a response, 3-cycle memory
        do_reset(3);
        mid();
        for (int c = 1; c <= 3; c++) begin
            nxt();
            mid();
        end
        nxt();
        flush_i      = 1'b1;
        flush_addr_i = 32'h0000_0200;
        mid();
        check("g_rv_f", {31'b0, mem_rvalid_i}, 32'd1);
        check("g_req_f", {31'b0, mem_req_o}, 32'd0);
        nxt();
        flush_i = 1'b0;
        mid();
        check("g_addr5", mem_addr_o, 32'h200);
        for (int c = 5; c <= 8; c++) begin
            if (c > 5) begin
                nxt();
                mid();
            end
            check("g_vld_lo", {31'b0, inst_valid_o}, 32'd0);
        end
        nxt();
        mid();
        chk_head("g_h0", 32'h200);
        nxt();
        mid();
        chk_head("g_h1", 32'h204);

        // Asynchronous reset with buffered and in-flight words
        do_reset(3);
        inst_ready_i = 1'b0;
        mid();
        for (int c = 1; c <= 6; c++) begin
            nxt();
            mid();
        end
        chk_head("r_pre", 32'h0);
        check("r_pre_req", {31'b0, mem_req_o}, 32'd0);
        rst = 1'b0;
        #1;
        check("r_req", {31'b0, mem_req_o}, 32'd0);
        check("r_vld", {31'b0, inst_valid_o}, 32'd0);
        check("r_inst", inst_o, 32'd0);
        check("r_iaddr", inst_addr_o, 32'd0);
        do_reset(1);
        inst_ready_i = 1'b1;
        mid();
        check("r_req_c0", {31'b0, mem_req_o}, 32'd0);
        nxt();
        mid();
        check("r_req_c1", {31'b0, mem_req_o}, 32'd1);
        check("r_addr_c1", mem_addr_o, 32'h0);
        nxt();
        mid();
        check("r_vld_c2", {31'b0, inst_valid_o}, 32'd0);
        nxt();
        mid();
        chk_head("r_h0", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
